// File: rtl/rgb_seq_pkg.sv
// Shared types for the RGB fade sequencer: phase encoding, colour masks and colour count.
package rgb_seq_pkg;

  localparam int unsigned NUM_COLOURS = 6;
  localparam int unsigned COLOUR_W    = 3;

  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,
    PH_RISE = 2'd1,
    PH_HOLD = 2'd2,
    PH_FALL = 2'd3
  } phase_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // Colour wheel: red, yellow, green, cyan, blue, magenta.
  function automatic rgb_t colour_mask(input logic [COLOUR_W-1:0] idx);
    case (idx)
      3'd0:    return rgb_t'(3'b100);
      3'd1:    return rgb_t'(3'b110);
      3'd2:    return rgb_t'(3'b010);
      3'd3:    return rgb_t'(3'b011);
      3'd4:    return rgb_t'(3'b001);
      3'd5:    return rgb_t'(3'b101);
      default: return rgb_t'(3'b000);
    endcase
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Free-running PWM counter with wrap-synchronous shadow duty and 3-channel masked compare.
module led_pwm_core
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [PWM_BITS-1:0] level,
  input  rgb_t                mask,
  output rgb_t                led
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow_duty;
  logic                on_c;

  assign on_c = (pwm_cnt < shadow_duty);

  // Clear bypasses the wrap latch so the LEDs drop on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt     <= '0;
      shadow_duty <= '0;
      led         <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (clear) begin
        shadow_duty <= '0;
        led         <= '0;
      end else begin
        if (pwm_cnt == CNT_MAX) shadow_duty <= level;
        led.r <= on_c & mask.r;
        led.g <= on_c & mask.g;
        led.b <= on_c & mask.b;
      end
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour-cycling LED fader: rise, hold and fall each colour on step_tick, then advance the colour.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned FADE_STEP  = 16,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_tick,
  input  logic       enable,
  output logic       redled,
  output logic       greenled,
  output logic       blueled,
  output logic [2:0] colour_idx,
  output logic [1:0] phase
);

  localparam int unsigned EXT_W    = PWM_BITS + 1;
  localparam int unsigned HOLD_EFF = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
  localparam int unsigned HOLD_W   = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

  localparam logic [EXT_W-1:0]    LVL_MAX     = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [EXT_W-1:0]    STEP_EXT    = EXT_W'(FADE_STEP);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_EFF - 1);
  localparam logic [COLOUR_W-1:0] LAST_COLOUR = COLOUR_W'(NUM_COLOURS - 1);

  phase_e                state, state_n;
  logic [PWM_BITS-1:0]   level, level_n;
  logic [HOLD_W-1:0]     hold_cnt, hold_n;
  logic [COLOUR_W-1:0]   colour_n;
  logic [EXT_W-1:0]      level_ext, sum_c, diff_c;
  rgb_t                  led;

  assign level_ext = {1'b0, level};
  assign sum_c     = level_ext + STEP_EXT;
  assign diff_c    = level_ext - STEP_EXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PH_OFF;
      level      <= '0;
      hold_cnt   <= '0;
      colour_idx <= '0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      hold_cnt   <= hold_n;
      colour_idx <= colour_n;
    end
  end

  // Disable wins over any coincident tick; saturation is done one bit wider than the level.
  always_comb begin
    state_n  = state;
    level_n  = level;
    hold_n   = hold_cnt;
    colour_n = colour_idx;
    if (!enable) begin
      state_n = PH_OFF;
      level_n = '0;
      hold_n  = '0;
    end else begin
      case (state)
        PH_OFF: begin
          state_n = PH_RISE;
          level_n = '0;
          hold_n  = '0;
        end
        PH_RISE: begin
          if (step_tick) begin
            if (sum_c >= LVL_MAX) begin
              level_n = PWM_BITS'(LVL_MAX);
              hold_n  = '0;
              state_n = PH_HOLD;
            end else begin
              level_n = PWM_BITS'(sum_c);
            end
          end
        end
        PH_HOLD: begin
          if (step_tick) begin
            if (hold_cnt >= HOLD_LAST) state_n = PH_FALL;
            else                       hold_n  = hold_cnt + HOLD_W'(1);
          end
        end
        PH_FALL: begin
          if (step_tick) begin
            if (level_ext <= STEP_EXT) begin
              level_n  = '0;
              state_n  = PH_RISE;
              colour_n = (colour_idx == LAST_COLOUR) ? '0 : colour_idx + COLOUR_W'(1);
            end else begin
              level_n = PWM_BITS'(diff_c);
            end
          end
        end
        default: state_n = PH_OFF;
      endcase
    end
  end

  led_pwm_core #(
    .PWM_BITS (PWM_BITS)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (~enable),
    .level (level),
    .mask  (colour_mask(colour_idx)),
    .led   (led)
  );

  assign redled   = led.r;
  assign greenled = led.g;
  assign blueled  = led.b;
  assign phase    = state;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with PWM_BITS=8, FADE_STEP=64, HOLD_TICKS=2.
module tb_rgb_fade_sequencer;

  logic       clk;
  logic       rst_n;
  logic       step_tick;
  logic       enable;
  logic       redled;
  logic       greenled;
  logic       blueled;
  logic [2:0] colour_idx;
  logic [1:0] phase;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_mask [6];

  rgb_fade_sequencer #(
    .PWM_BITS   (8),
    .FADE_STEP  (64),
    .HOLD_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_tick  (step_tick),
    .enable     (enable),
    .redled     (redled),
    .greenled   (greenled),
    .blueled    (blueled),
    .colour_idx (colour_idx),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    step_tick = 1'b1;
    clk_step();
    step_tick = 1'b0;
  endtask

  // Align to a PWM wrap, then count LED-high samples over one full 256-clk period.
  task automatic measure(input int tick_at, output int rc, output int gc, output int bc);
    int guard;
    guard = 0;
    rc = 0; gc = 0; bc = 0;
    while (dut.u_core.pwm_cnt !== 8'd255 && guard < 300) begin
      clk_step();
      guard++;
    end
    check("wrap_seen", 32'(guard < 300), 1);
    for (int k = 1; k <= 257; k++) begin
      if (k == tick_at) step_tick = 1'b1;
      clk_step();
      step_tick = 1'b0;
      if (k >= 2) begin
        rc += int'(redled);
        gc += int'(greenled);
        bc += int'(blueled);
      end
    end
  endtask

  task automatic full_cycle(input int cidx);
    logic [2:0] m;
    int r, g, b;
    m = exp_mask[cidx];
    repeat (4) do_tick();
    check("cyc_hold_phase", 32'(phase), 2);
    check("cyc_hold_level", 32'(dut.level), 255);
    measure(-1, r, g, b);
    check("cyc_red", 32'(r), 32'(m[2]) * 255);
    check("cyc_green", 32'(g), 32'(m[1]) * 255);
    check("cyc_blue", 32'(b), 32'(m[0]) * 255);
    repeat (6) do_tick();
    check("cyc_next_phase", 32'(phase), 1);
    check("cyc_next_colour", 32'(colour_idx), 32'((cidx + 1) % 6));
  endtask

  initial begin
    int r, g, b;
    exp_mask[0] = 3'b100; exp_mask[1] = 3'b110; exp_mask[2] = 3'b010;
    exp_mask[3] = 3'b011; exp_mask[4] = 3'b001; exp_mask[5] = 3'b101;
    rst_n = 1'b0; enable = 1'b0; step_tick = 1'b0;
    repeat (3) clk_step();
    check("rst_phase", 32'(phase), 0);
    check("rst_colour", 32'(colour_idx), 0);
    check("rst_leds", 32'({redled, greenled, blueled}), 0);
    check("rst_level", 32'(dut.level), 0);

    // First ramp on red, including a 50% duty period and a mid-period level change.
    rst_n = 1'b1;
    enable = 1'b1;
    clk_step();
    check("start_phase", 32'(phase), 1);
    check("start_level", 32'(dut.level), 0);
    do_tick();
    check("rise1_level", 32'(dut.level), 64);
    do_tick();
    check("rise2_level", 32'(dut.level), 128);
    measure(100, r, g, b);
    check("duty128_red", 32'(r), 128);
    check("duty128_green", 32'(g), 0);
    check("duty128_blue", 32'(b), 0);
    check("rise3_level", 32'(dut.level), 192);
    measure(-1, r, g, b);
    check("duty192_red", 32'(r), 192);
    check("duty192_gb", 32'(g + b), 0);
    do_tick();
    check("rise4_level", 32'(dut.level), 255);
    check("rise4_phase", 32'(phase), 2);
    check("rise4_colour", 32'(colour_idx), 0);

    // Hold for two ticks, then fall back to zero and advance to yellow.
    do_tick();
    check("hold1_phase", 32'(phase), 2);
    do_tick();
    check("hold2_phase", 32'(phase), 3);
    check("hold2_level", 32'(dut.level), 255);
    do_tick();
    check("fall1_level", 32'(dut.level), 191);
    do_tick();
    check("fall2_level", 32'(dut.level), 127);
    do_tick();
    check("fall3_level", 32'(dut.level), 63);
    check("fall3_phase", 32'(phase), 3);
    do_tick();
    check("fall4_level", 32'(dut.level), 0);
    check("fall4_phase", 32'(phase), 1);
    check("fall4_colour", 32'(colour_idx), 1);
    do_tick();
    measure(-1, r, g, b);
    check("yellow_red", 32'(r), 64);
    check("yellow_green", 32'(g), 64);
    check("yellow_blue", 32'(b), 0);

    // Disable coinciding with a tick in RISE: tick dropped, immediate OFF.
    enable = 1'b0;
    step_tick = 1'b1;
    clk_step();
    step_tick = 1'b0;
    check("dis_phase", 32'(phase), 0);
    check("dis_level", 32'(dut.level), 0);
    check("dis_leds", 32'({redled, greenled, blueled}), 0);
    check("dis_colour", 32'(colour_idx), 1);
    do_tick();
    check("off_tick_phase", 32'(phase), 0);
    check("off_tick_level", 32'(dut.level), 0);
    check("off_tick_leds", 32'({redled, greenled, blueled}), 0);

    // Six full colour cycles starting from yellow, wrapping 5 -> 0.
    enable = 1'b1;
    clk_step();
    check("reen_phase", 32'(phase), 1);
    check("reen_colour", 32'(colour_idx), 1);
    for (int i = 0; i < 6; i++) full_cycle((1 + i) % 6);

    // Advance to cyan mid-fall, then assert reset between clock edges.
    full_cycle(1);
    full_cycle(2);
    repeat (8) do_tick();
    check("midfall_phase", 32'(phase), 3);
    check("midfall_level", 32'(dut.level), 127);
    check("midfall_colour", 32'(colour_idx), 3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_phase", 32'(phase), 0);
    check("arst_colour", 32'(colour_idx), 0);
    check("arst_leds", 32'({redled, greenled, blueled}), 0);
    check("arst_level", 32'(dut.level), 0);
    check("arst_cnt", 32'(dut.u_core.pwm_cnt), 0);
    enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clk_step();
    check("rel_phase", 32'(phase), 0);
    check("rel_colour", 32'(colour_idx), 0);
    check("rel_cnt", 32'(dut.u_core.pwm_cnt), 1);
    enable = 1'b1;
    clk_step();
    check("rel_rise_phase", 32'(phase), 1);
    check("rel_rise_level", 32'(dut.level), 0);
    check("rel_rise_colour", 32'(colour_idx), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, meaning PWM resolution in bits.
REQ-002 SHALL have parameter FADE_STEP, default 16, meaning level increment or decrement per step_tick.
REQ-003 SHALL have parameter HOLD_TICKS, default 4, meaning step_ticks spent at full brightness.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock (Sys_Clk0 domain).
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port step_tick, input, 1, meaning a one-clk pulse from the upstream tick/blink divider.
REQ-007 SHALL have port enable, input, 1, meaning run the sequence when high.
REQ-008 SHALL have port redled, output, 1, meaning red LED drive, active high.
REQ-009 SHALL have port greenled, output, 1, meaning green LED drive, active high.
REQ-010 SHALL have port blueled, output, 1, meaning blue LED drive, active high.
REQ-011 SHALL have port colour_idx, output, 3, meaning the current colour, 0..5.
REQ-012 SHALL have port phase, output, 2, meaning the FSM state: OFF=0, RISE=1, HOLD=2, FALL=3.

Function
REQ-013 SHALL run a free-running PWM_BITS counter that increments every clk and wraps from 2^PWM_BITS-1 to 0.
REQ-014 SHALL keep a working level (PWM_BITS wide) and latch it into a shadow duty only on the PWM counter wrap cycle, so there are no mid-period glitches.
REQ-015 SHALL drive each LED as (pwm_cnt < shadow_duty) AND that channel's mask bit, registered with 1 clk latency; level 255 gives 255/256 on-time and level 0 gives constantly low.
REQ-016 SHALL use the following colour masks {R,G,B}, indexed 0..5: 100 red, 110 yellow, 010 green, 011 cyan, 001 blue, 101 magenta.
REQ-017 SHALL implement the FSM transitions below; all transitions other than OFF->RISE are evaluated only on cycles where step_tick=1.
REQ-018 SHALL move OFF->RISE on the first clk with enable=1, with level=0.
REQ-019 SHALL, in RISE, set level=min(level+FADE_STEP, max); on reaching max SHALL enter HOLD with hold_cnt=0.
REQ-020 SHALL, in HOLD, increment hold_cnt; when hold_cnt reaches HOLD_TICKS-1 on a tick SHALL enter FALL.
REQ-021 SHALL, in FALL, set level=max(level-FADE_STEP, 0); on reaching 0 SHALL enter RISE and advance colour_idx by 1, wrapping 5->0.
REQ-022 SHALL compute the saturation arithmetic at PWM_BITS+1 width; the level SHALL never wrap.
REQ-023 SHALL, when enable=0 in any state, enter OFF on the next clk with level=0 and all LEDs low within 1 clk, bypassing the shadow latch; colour_idx is retained.
REQ-024 SHALL give enable=0 priority when it coincides with step_tick; the tick is dropped.
REQ-025 SHALL treat a step_tick in OFF as having no effect.
REQ-026 SHALL treat HOLD_TICKS=0 as 1.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear pwm_cnt, level, shadow_duty, hold_cnt and colour_idx to 0, set phase=OFF and drive all LED outputs to 0.
REQ-028 SHALL release from reset synchronously to clk; the first PWM period after release begins at pwm_cnt=0.
REQ-029 SHALL, on reset asserted mid-fade, abandon the sequence; after release it restarts at colour 0, RISE from level 0.

Structure
REQ-030 SHALL place the phase enum, the colour-mask table and the colour count (6) in the shared package rgb_seq_pkg.
REQ-031 SHALL implement the counter and comparator in one sub-module, led_pwm_core (counter, shadow latch, 3-channel compare), instantiated once.
REQ-032 SHALL keep the FSM and level arithmetic in rgb_fade_sequencer.

Verification (PWM_BITS=8, FADE_STEP=64, HOLD_TICKS=2)
REQ-033 Bench SHALL cover: reset, then enable=1, then 4 ticks -> level 64,128,192,255 (saturated); phase RISE->HOLD on the 4th tick; colour_idx=0; only redled toggles.
REQ-034 Bench SHALL cover: continue with 2 ticks -> FALL; 4 more ticks -> level 191,127,63,0; phase RISE; colour_idx=1; redled and greenled both pulse.
REQ-035 Bench SHALL cover: level=128 steady -> redled high for exactly 128 of each 256 clks; duty changes only at pwm_cnt wrap.
REQ-036 Bench SHALL cover: enable=0 asserted on the same clk as step_tick in RISE -> next clk phase=OFF, LEDs 0, level 0, colour_idx unchanged.
REQ-037 Bench SHALL cover: drive 6 full colour cycles -> colour_idx 5 wraps to 0; mask sequence matches the table.
REQ-038 Bench SHALL cover: rst_n pulsed low mid-FALL on colour 3 -> outputs 0 immediately (asynchronous); after release colour_idx=0, phase=OFF, then RISE once enable=1.
